// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and lock supervisor for the iCE40 PLL wrapper.
// Pulses the PLL's active-low reset, then waits for LOCK to stay high long enough
// before it releases the fast-domain reset. When lock is lost it re-initialises
// the PLL. After a bounded number of failed attempts it latches a fault, which
// stays until software clears it.
module pll_lock_sequencer #(
    parameter int unsigned RESETB_PULSE_CYCLES = 12,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 120000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       clear_fault,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESETB_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           cur_state;
    logic             lock_m;
    logic             lock_s;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] stable;
    logic [3:0]       retry_next;

    assign retry_next = retry_count + 4'd1;
    assign state      = cur_state;

    // Two-flop synchroniser for the asynchronous PLL LOCK signal
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    // Sequencer FSM; every output is driven here so all of them come from flops
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cur_state       <= ST_RESET_PLL;
            timer           <= '0;
            stable          <= '0;
            pll_resetb      <= 1'b0;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else begin
            case (cur_state)
                ST_RESET_PLL: begin
                    pll_resetb <= 1'b0;
                    sys_reset  <= 1'b1;
                    ready      <= 1'b0;
                    if (timer == PULSE_LAST) begin
                        cur_state  <= ST_WAIT_LOCK;
                        timer      <= '0;
                        stable     <= '0;
                        pll_resetb <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    timer  <= timer + 1'b1;
                    stable <= lock_s ? stable + 1'b1 : '0;
                    // The stable check comes first, so a lock that qualifies on the timeout cycle still wins
                    if (stable == STABLE_DONE) begin
                        cur_state   <= ST_RUN;
                        retry_count <= '0;
                        ready       <= 1'b1;
                        sys_reset   <= 1'b0;
                        timer       <= '0;
                        stable      <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_count <= retry_next;
                        timer       <= '0;
                        stable      <= '0;
                        pll_resetb  <= 1'b0;
                        if (retry_next == RETRY_LIMIT) begin
                            cur_state <= ST_FAULT;
                            fault     <= 1'b1;
                        end else begin
                            cur_state <= ST_RESET_PLL;
                        end
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        cur_state  <= ST_RESET_PLL;
                        ready      <= 1'b0;
                        sys_reset  <= 1'b1;
                        pll_resetb <= 1'b0;
                        timer      <= '0;
                        if (lock_loss_count != 8'hFF) begin
                            lock_loss_count <= lock_loss_count + 8'd1;
                        end
                    end
                end

                ST_FAULT: begin
                    if (clear_fault) begin
                        cur_state   <= ST_RESET_PLL;
                        fault       <= 1'b0;
                        retry_count <= '0;
                        timer       <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer. The stimulus process queues the
// expected output snapshot for each cycle it cares about. The monitor samples
// the outputs on the falling edge and compares them with the queued entry
// when that cycle arrives.
module tb_pll_lock_sequencer;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       clear_fault;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [1:0] state;

    pll_lock_sequencer #(
        .RESETB_PULSE_CYCLES(4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(40),
        .MAX_RETRIES        (2),
        .CNT_W              (8)
    ) dut (
        .clock_in       (clock_in),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .clear_fault    (clear_fault),
        .pll_resetb     (pll_resetb),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 clock_in = ~clock_in;

    // Number of rising edges seen so far
    int unsigned cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [17:0] vec;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Expected output snapshot {state, pll_resetb, sys_reset, ready, fault, retry_count, lock_loss_count}
    function automatic logic [17:0] model(input logic [1:0] st, input logic [3:0] rc, input logic [7:0] llc);
        logic [3:0] ctl;
        case (st)
            2'd0:    ctl = 4'b0100;
            2'd1:    ctl = 4'b1100;
            2'd2:    ctl = 4'b1010;
            default: ctl = 4'b0101;
        endcase
        return {st, ctl, rc, llc};
    endfunction

    task automatic expect_at(input int unsigned c, input string nm, input logic [1:0] st,
                             input logic [3:0] rc, input logic [7:0] llc);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.vec  = model(st, rc, llc);
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clock_in);
    endtask

    // Monitor: compare every queued expectation whose cycle has been reached
    exp_t        mon_e;
    logic [17:0] got_v;
    always @(negedge clock_in) begin
        got_v = {state, pll_resetb, sys_reset, ready, fault, retry_count, lock_loss_count};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (mon_e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: checked late at cyc=%0d, required cyc=%0d", mon_e.name, cyc, mon_e.cyc);
            end else if (got_v !== mon_e.vec) begin
                bad++;
                $display("FAIL %s cyc=%0d got st=%0d rb=%b sr=%b rdy=%b flt=%b rc=%0d llc=%0d want st=%0d rb=%b sr=%b rdy=%b flt=%b rc=%0d llc=%0d",
                         mon_e.name, cyc,
                         got_v[17:16], got_v[15], got_v[14], got_v[13], got_v[12], got_v[11:8], got_v[7:0],
                         mon_e.vec[17:16], mon_e.vec[15], mon_e.vec[14], mon_e.vec[13], mon_e.vec[12],
                         mon_e.vec[11:8], mon_e.vec[7:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int unsigned c;
        reset       = 1'b1;
        pll_locked  = 1'b0;
        clear_fault = 1'b0;
        @(negedge clock_in);
        expect_at(2, "reset_values", 2'd0, 4'd0, 8'd0);
        wait_cyc(2);

        // Bring-up: 4-cycle resetb pulse, lock raised 2 cycles after resetb rises
        c = cyc;
        reset = 1'b0;
        expect_at(c + 3,  "s1_resetb_low_last", 2'd0, 4'd0, 8'd0);
        expect_at(c + 4,  "s1_resetb_release",  2'd1, 4'd0, 8'd0);
        expect_at(c + 15, "s1_not_ready_yet",   2'd1, 4'd0, 8'd0);
        expect_at(c + 16, "s1_ready",           2'd2, 4'd0, 8'd0);
        wait_cyc(c + 5);
        pll_locked = 1'b1;
        wait_cyc(c + 16);

        // Single-cycle lock drop in RUN, then relock
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 2,  "s4_still_run",       2'd2, 4'd0, 8'd0);
        expect_at(c + 3,  "s4_loss_reset",      2'd0, 4'd0, 8'd1);
        expect_at(c + 6,  "s4_resetb_low_last", 2'd0, 4'd0, 8'd1);
        expect_at(c + 7,  "s4_wait",            2'd1, 4'd0, 8'd1);
        expect_at(c + 15, "s4_wait_last",       2'd1, 4'd0, 8'd1);
        expect_at(c + 16, "s4_relock",          2'd2, 4'd0, 8'd1);
        wait_cyc(c + 1);
        pll_locked = 1'b1;
        wait_cyc(c + 16);

        // Losses 2..300: lock_loss_count saturates at 255
        for (int unsigned n = 2; n <= 300; n++) begin
            c = cyc;
            pll_locked = 1'b0;
            expect_at(c + 3,  "s4_loss_count",  2'd0, 4'd0, (n > 255) ? 8'd255 : 8'(n));
            expect_at(c + 16, "s4_loss_relock", 2'd2, 4'd0, (n > 255) ? 8'd255 : 8'(n));
            wait_cyc(c + 1);
            pll_locked = 1'b1;
            wait_cyc(c + 16);
        end

        // Glitch in WAIT_LOCK after 5 stable cycles restarts the stable count
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 3,  "s2_loss_reset",      2'd0, 4'd0, 8'd255);
        expect_at(c + 7,  "s2_wait",            2'd1, 4'd0, 8'd255);
        expect_at(c + 18, "s2_glitch_held_off", 2'd1, 4'd0, 8'd255);
        expect_at(c + 23, "s2_no_ready_yet",    2'd1, 4'd0, 8'd255);
        expect_at(c + 24, "s2_ready_after_8",   2'd2, 4'd0, 8'd255);
        wait_cyc(c + 7);
        pll_locked = 1'b1;
        wait_cyc(c + 12);
        pll_locked = 1'b0;
        wait_cyc(c + 13);
        pll_locked = 1'b1;
        wait_cyc(c + 24);

        // Stable completes on the same cycle as the timeout (timer=39)
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 7,  "s5_wait",        2'd1, 4'd0, 8'd255);
        expect_at(c + 46, "s5_timer39",     2'd1, 4'd0, 8'd255);
        expect_at(c + 47, "s5_stable_wins", 2'd2, 4'd0, 8'd255);
        wait_cyc(c + 36);
        pll_locked = 1'b1;
        wait_cyc(c + 47);

        // No lock: two 40-cycle windows then FAULT; a short blip does not restart the timer
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 7,   "s3_win1_start",         2'd1, 4'd0, 8'd255);
        expect_at(c + 46,  "s3_win1_last",          2'd1, 4'd0, 8'd255);
        expect_at(c + 47,  "s3_timeout1",           2'd0, 4'd1, 8'd255);
        expect_at(c + 50,  "s3_pulse2_last",        2'd0, 4'd1, 8'd255);
        expect_at(c + 51,  "s3_win2_start",         2'd1, 4'd1, 8'd255);
        expect_at(c + 90,  "s3_win2_last",          2'd1, 4'd1, 8'd255);
        expect_at(c + 91,  "s3_fault",              2'd3, 4'd2, 8'd255);
        expect_at(c + 100, "s3_fault_ignores_lock", 2'd3, 4'd2, 8'd255);
        expect_at(c + 101, "s3_clear",              2'd0, 4'd0, 8'd255);
        expect_at(c + 104, "s3_clear_pulse_last",   2'd0, 4'd0, 8'd255);
        expect_at(c + 105, "s3_clear_wait",         2'd1, 4'd0, 8'd255);
        expect_at(c + 114, "s3_relock",             2'd2, 4'd0, 8'd255);
        wait_cyc(c + 12);
        pll_locked = 1'b1;
        wait_cyc(c + 15);
        pll_locked = 1'b0;
        wait_cyc(c + 92);
        pll_locked = 1'b1;
        wait_cyc(c + 100);
        clear_fault = 1'b1;
        wait_cyc(c + 101);
        clear_fault = 1'b0;
        wait_cyc(c + 114);

        // clear_fault outside FAULT is ignored; reset mid-WAIT_LOCK and in FAULT
        c = cyc;
        clear_fault = 1'b1;
        expect_at(c + 1,   "s6_clear_in_run",       2'd2, 4'd0, 8'd255);
        expect_at(c + 6,   "s6_loss_reset",         2'd0, 4'd0, 8'd255);
        expect_at(c + 10,  "s6_wait",               2'd1, 4'd0, 8'd255);
        expect_at(c + 13,  "s6_clear_in_wait",      2'd1, 4'd0, 8'd255);
        expect_at(c + 15,  "s6_pre_reset",          2'd1, 4'd0, 8'd255);
        expect_at(c + 16,  "s6_reset_mid_wait",     2'd0, 4'd0, 8'd0);
        expect_at(c + 20,  "s6_wait_after_reset",   2'd1, 4'd0, 8'd0);
        expect_at(c + 60,  "s6_timeout1",           2'd0, 4'd1, 8'd0);
        expect_at(c + 104, "s6_fault",              2'd3, 4'd2, 8'd0);
        expect_at(c + 107, "s6_reset_in_fault",     2'd0, 4'd0, 8'd0);
        expect_at(c + 111, "s6_wait_after_reset2",  2'd1, 4'd0, 8'd0);
        expect_at(c + 119, "s6_no_ready_yet",       2'd1, 4'd0, 8'd0);
        expect_at(c + 120, "s6_relock_after_reset", 2'd2, 4'd0, 8'd0);
        wait_cyc(c + 1);
        clear_fault = 1'b0;
        wait_cyc(c + 3);
        pll_locked = 1'b0;
        wait_cyc(c + 12);
        clear_fault = 1'b1;
        wait_cyc(c + 13);
        clear_fault = 1'b0;
        wait_cyc(c + 15);
        reset = 1'b1;
        wait_cyc(c + 16);
        reset = 1'b0;
        wait_cyc(c + 106);
        reset = 1'b1;
        pll_locked = 1'b1;
        wait_cyc(c + 107);
        reset = 1'b0;
        wait_cyc(c + 122);

        for (int unsigned i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock_in);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb.size());
            bad = bad + sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
